// File: rtl/alu_pkg.sv
// Operation encoding shared by the ALU and every block that drives it.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_LUI  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_SRA  = 4'd10
    } alu_operation_type;

endpackage

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU:
// accept, drive the ALU for one cycle, return a tagged registered response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [1:0]                       req_valid,
    output logic [1:0]                       req_ready,
    input  logic [1:0][DATA_WIDTH-1:0]       req_a,
    input  logic [1:0][DATA_WIDTH-1:0]       req_b,
    input  alu_operation_type [1:0]          req_op,
    output logic [DATA_WIDTH-1:0]            alu_a,
    output logic [DATA_WIDTH-1:0]            alu_b,
    output alu_operation_type                alu_op,
    input  logic [DATA_WIDTH-1:0]            alu_result,
    input  logic                             alu_zero,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic                             rsp_id,
    output logic [DATA_WIDTH-1:0]            rsp_result,
    output logic                             rsp_zero,
    output logic                             rsp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0]   lat_a_q, lat_a_d;
    logic [DATA_WIDTH-1:0]   lat_b_q, lat_b_d;
    alu_operation_type       lat_op_q, lat_op_d;
    logic                    lat_id_q, lat_id_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic                    rsp_zero_q, rsp_zero_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    grant_vld;
    logic                    grant_id;
    logic                    exec_legal;

    function automatic logic op_is_legal(input alu_operation_type op);
        logic legal;
        case (op)
            ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_LUI, ALU_XOR,
            ALU_OR, ALU_AND, ALU_SLT, ALU_SLTU, ALU_SRA: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_vld = (state_q == IDLE) && (req_valid != 2'b00);
        if (req_valid == 2'b11) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req_valid[1];
        end
    end

    always_comb begin
        req_ready = 2'b00;
        if (grant_vld) begin
            req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    assign exec_legal = op_is_legal(lat_op_q);

    // Illegal ops never reach the ALU; it sees the same quiet ADD 0,0 as idle.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = '0;
        alu_b  = '0;
        if ((state_q == EXEC) && exec_legal) begin
            alu_op = lat_op_q;
            alu_a  = lat_a_q;
            alu_b  = lat_b_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lat_a_d      = lat_a_q;
        lat_b_d      = lat_b_q;
        lat_op_d     = lat_op_q;
        lat_id_d     = lat_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    lat_a_d      = req_a[grant_id];
                    lat_b_d      = req_b[grant_id];
                    lat_op_d     = req_op[grant_id];
                    lat_id_d     = grant_id;
                    last_grant_d = grant_id;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_id_d     = lat_id_q;
                rsp_result_d = exec_legal ? alu_result : '0;
                rsp_zero_d   = exec_legal ? alu_zero : 1'b0;
                rsp_err_d    = ~exec_legal;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Reset leaves last_grant at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            lat_a_q      <= '0;
            lat_b_q      <= '0;
            lat_op_q     <= ALU_ADD;
            lat_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lat_a_q      <= lat_a_d;
            lat_b_q      <= lat_b_d;
            lat_op_q     <= lat_op_d;
            lat_id_q     <= lat_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int DW = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][DW-1:0]    req_a;
    logic [1:0][DW-1:0]    req_b;
    alu_operation_type [1:0] req_op;
    logic [DW-1:0]         alu_a, alu_b, alu_result;
    alu_operation_type     alu_op;
    logic                  alu_zero;
    logic                  rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [DW-1:0]         rsp_result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              id;
        alu_operation_type op;
        logic [DW-1:0]     a;
        logic [DW-1:0]     b;
        logic [DW-1:0]     res;
        logic              zero;
        logic              err;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err)
    );

    // Behavioural ALU; an unknown op yields a marker value so leakage is visible.
    always_comb begin
        alu_result = 32'hDEAD_BEEF;
        case (alu_op)
            ALU_ADD:  alu_result = alu_a + alu_b;
            ALU_SUB:  alu_result = alu_a - alu_b;
            ALU_SLL:  alu_result = alu_a << alu_b[4:0];
            ALU_SRL:  alu_result = alu_a >> alu_b[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            ALU_LUI:  alu_result = alu_b;
            ALU_XOR:  alu_result = alu_a ^ alu_b;
            ALU_OR:   alu_result = alu_a | alu_b;
            ALU_AND:  alu_result = alu_a & alu_b;
            ALU_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_result = {31'd0, alu_a < alu_b};
            default:  alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE with rsp_ready high; ends at a negedge back in IDLE.
    task automatic run_txn(input vec_t v, input int idx);
        req_valid = v.id ? 2'b10 : 2'b01;
        req_a[v.id]  = v.a;
        req_b[v.id]  = v.b;
        req_op[v.id] = v.op;
        req_a[~v.id] = 32'h1357_9BDF;
        req_b[~v.id] = 32'h2468_ACE0;
        req_op[~v.id] = ALU_OR;
        #1;
        check($sformatf("v%0d ready", idx), req_ready, v.id ? 2'b10 : 2'b01);
        @(negedge clk);
        req_valid    = 2'b00;
        req_a[v.id]  = ~v.a;
        req_op[v.id] = ALU_SUB;
        #1;
        check($sformatf("v%0d exec_op", idx), alu_op, v.err ? ALU_ADD : v.op);
        check($sformatf("v%0d exec_a", idx), alu_a, v.err ? 32'd0 : v.a);
        check($sformatf("v%0d exec_b", idx), alu_b, v.err ? 32'd0 : v.b);
        check($sformatf("v%0d exec_nrdy", idx), req_ready, 2'b00);
        check($sformatf("v%0d exec_nvld", idx), rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        check($sformatf("v%0d rsp_valid", idx), rsp_valid, 1'b1);
        check($sformatf("v%0d rsp_id", idx), rsp_id, v.id);
        check($sformatf("v%0d rsp_result", idx), rsp_result, v.res);
        check($sformatf("v%0d rsp_zero", idx), rsp_zero, v.zero);
        check($sformatf("v%0d rsp_err", idx), rsp_err, v.err);
        @(negedge clk);
        #1;
        check($sformatf("v%0d idle_nvld", idx), rsp_valid, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, ALU_ADD,  32'd5,         32'd3,         32'd8,         1'b0, 1'b0};
        vecs[1]  = '{1'b1, ALU_SUB,  32'd7,         32'd7,         32'd0,         1'b1, 1'b0};
        vecs[2]  = '{1'b0, ALU_XOR,  32'hF0F0F0F0,  32'h0F0F0F0F,  32'hFFFFFFFF,  1'b0, 1'b0};
        vecs[3]  = '{1'b1, ALU_SLT,  32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1'b0};
        vecs[4]  = '{1'b1, ALU_SLTU, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0};
        vecs[5]  = '{1'b0, ALU_SRA,  32'h80000000,  32'd4,         32'hF8000000,  1'b0, 1'b0};
        vecs[6]  = '{1'b0, ALU_SRL,  32'h80000000,  32'd4,         32'h08000000,  1'b0, 1'b0};
        vecs[7]  = '{1'b1, ALU_SLL,  32'd1,         32'd31,        32'h80000000,  1'b0, 1'b0};
        vecs[8]  = '{1'b0, ALU_AND,  32'hFF00FF00,  32'h0FF00FF0,  32'h0F000F00,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, ALU_OR,   32'h0000F000,  32'h0000000F,  32'h0000F00F,  1'b0, 1'b0};
        vecs[10] = '{1'b0, alu_operation_type'(4'd13), 32'd5, 32'd3,  32'd0,         1'b0, 1'b1};
        vecs[11] = '{1'b1, ALU_ADD,  32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0};
        vecs[12] = '{1'b0, ALU_LUI,  32'd0,         32'h12345000,  32'h12345000,  1'b0, 1'b0};

        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        req_op    = {ALU_ADD, ALU_ADD};
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("rst rsp_valid", rsp_valid, 1'b0);
        check("rst req_ready", req_ready, 2'b00);
        check("rst rsp_result", rsp_result, 32'd0);
        check("rst rsp_id", rsp_id, 1'b0);
        check("rst rsp_err", rsp_err, 1'b0);
        check("rst alu_op", alu_op, ALU_ADD);
        check("rst alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i], i);
        end

        // Round-robin with both requesters asserted: grants 0,1,0,1 three cycles apart.
        do_reset();
        req_a[0] = 32'd1; req_b[0] = 32'd1; req_op[0] = ALU_ADD;
        req_a[1] = 32'd2; req_b[1] = 32'd2; req_op[1] = ALU_ADD;
        req_valid = 2'b11;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (k % 3 == 0) begin
                check($sformatf("rr%0d ready", k), req_ready, ((k / 3) % 2 == 0) ? 2'b01 : 2'b10);
            end else begin
                check($sformatf("rr%0d nready", k), req_ready, 2'b00);
            end
            if (k % 3 == 2) begin
                check($sformatf("rr%0d rsp_id", k), rsp_id, (k / 3) % 2);
                check($sformatf("rr%0d rsp_result", k), rsp_result, ((k / 3) % 2 == 0) ? 32'd2 : 32'd4);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;

        // Backpressure: response held five cycles while both requesters wait.
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        req_a[0] = 32'hF0F0F0F0; req_b[0] = 32'h0F0F0F0F; req_op[0] = ALU_XOR;
        #1;
        check("bp ready", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp%0d rsp_valid", k), rsp_valid, 1'b1);
            check($sformatf("bp%0d rsp_result", k), rsp_result, 32'hFFFFFFFF);
            check($sformatf("bp%0d nready", k), req_ready, 2'b00);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp release vld", rsp_valid, 1'b1);
        check("bp release nrdy", req_ready, 2'b00);
        @(negedge clk);
        #1;
        check("bp idle nvld", rsp_valid, 1'b0);
        check("bp idle grant1", req_ready, 2'b10);
        req_valid = 2'b00;

        // Async reset while requester 0 is in EXEC.
        @(negedge clk);
        req_valid = 2'b01;
        req_a[0] = 32'd9; req_b[0] = 32'd1; req_op[0] = ALU_ADD;
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        check("ar exec_a", alu_a, 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar rsp_valid", rsp_valid, 1'b0);
        check("ar rsp_result", rsp_result, 32'd0);
        check("ar alu_a", alu_a, 32'd0);
        check("ar alu_op", alu_op, ALU_ADD);
        check("ar req_ready", req_ready, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("ar%0d nvld", k), rsp_valid, 1'b0);
        end
        req_valid = 2'b11;
        #1;
        check("ar tie grant0", req_ready, 2'b01);
        req_valid = 2'b00;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
